// File: rtl/regfile_mp_if.sv
// regfile_mp_if: read, write, reservation and scoreboard bundle of regfile_mp.
// master = decode/writeback side, slave = register file.
interface regfile_mp_if #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int NRD   = 2
);
    localparam int AW = $clog2(NREGS);

    logic [NRD*AW-1:0]   rd_addr;
    logic [NRD*XLEN-1:0] rd_data;
    logic [NRD-1:0]      rd_busy;
    logic                wa_en;
    logic [AW-1:0]       wa_addr;
    logic [XLEN-1:0]     wa_data;
    logic                wb_en;
    logic [AW-1:0]       wb_addr;
    logic [XLEN-1:0]     wb_data;
    logic                rsv_en;
    logic [AW-1:0]       rsv_addr;
    logic [NREGS-1:0]    busy;

    modport master (
        output rd_addr,
        output wa_en, wa_addr, wa_data,
        output wb_en, wb_addr, wb_data,
        output rsv_en, rsv_addr,
        input  rd_data, rd_busy, busy
    );

    modport slave (
        input  rd_addr,
        input  wa_en, wa_addr, wa_data,
        input  wb_en, wb_addr, wb_data,
        input  rsv_en, rsv_addr,
        output rd_data, rd_busy, busy
    );
endinterface

// File: rtl/regfile_mp.sv
// regfile_mp: multi-port integer register file with a per-register busy scoreboard.
// Define REGFILE_BYPASS_EN for same-cycle write-to-read bypass.
module regfile_mp #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int NRD   = 2
) (
    input logic         clk,
    input logic         reset,
    regfile_mp_if.slave rf
);
    localparam int AW = $clog2(NREGS);

    logic [XLEN-1:0]  regs_q [1:NREGS-1];
    logic [XLEN-1:0]  regs_d [1:NREGS-1];
    logic [NREGS-1:1] busy_q;
    logic [NREGS-1:1] busy_d;

    logic wa_hit;
    logic wb_hit;
    logic rsv_hit;

    assign wa_hit  = rf.wa_en  && (rf.wa_addr  != '0);
    assign wb_hit  = rf.wb_en  && (rf.wb_addr  != '0);
    assign rsv_hit = rf.rsv_en && (rf.rsv_addr != '0);

    // Port B applied after A so the load wins; reservation last so it wins over a clear.
    always_comb begin
        regs_d = regs_q;
        busy_d = busy_q;
        if (wa_hit) begin
            regs_d[rf.wa_addr] = rf.wa_data;
            busy_d[rf.wa_addr] = 1'b0;
        end
        if (wb_hit) begin
            regs_d[rf.wb_addr] = rf.wb_data;
            busy_d[rf.wb_addr] = 1'b0;
        end
        if (rsv_hit) begin
            busy_d[rf.rsv_addr] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 1; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
            busy_q <= '0;
        end else begin
            regs_q <= regs_d;
            busy_q <= busy_d;
        end
    end

    assign rf.busy = {busy_q, 1'b0};

    genvar k;
    generate
        for (k = 0; k < NRD; k++) begin : g_rd
            logic [AW-1:0]   ra;
            logic [XLEN-1:0] data;
            logic            bsy;

            assign ra = rf.rd_addr[k*AW +: AW];

            always_comb begin
                data = '0;
                bsy  = 1'b0;
                if (ra != '0) begin
                    data = regs_q[ra];
                    bsy  = busy_q[ra];
`ifdef REGFILE_BYPASS_EN
                    if (!reset && wa_hit && (rf.wa_addr == ra)) begin
                        data = rf.wa_data;
                        bsy  = rsv_hit && (rf.rsv_addr == ra);
                    end
                    if (!reset && wb_hit && (rf.wb_addr == ra)) begin
                        data = rf.wb_data;
                        bsy  = rsv_hit && (rf.rsv_addr == ra);
                    end
`endif
                end
            end

            assign rf.rd_data[k*XLEN +: XLEN] = data;
            assign rf.rd_busy[k]              = bsy;
        end
    endgenerate
endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: random and directed checks of regfile_mp against a behavioural model.
// Covers a 32x32/3-port instance and a 16x16/4-port instance.
module tb_regfile_mp;
    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    regfile_mp_if #(.XLEN(32), .NREGS(32), .NRD(3)) rf0 ();
    regfile_mp_if #(.XLEN(16), .NREGS(16), .NRD(4)) rf1 ();

    regfile_mp #(.XLEN(32), .NREGS(32), .NRD(3)) u0 (
        .clk(clk), .reset(reset), .rf(rf0)
    );
    regfile_mp #(.XLEN(16), .NREGS(16), .NRD(4)) u1 (
        .clk(clk), .reset(reset), .rf(rf1)
    );

    int passed = 0;
    int total  = 0;

    logic [31:0] mregs [32];
    logic        mbusy [32];

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    endtask

    task automatic model_clear();
        for (int i = 0; i < 32; i++) begin
            mregs[i] = '0;
            mbusy[i] = 1'b0;
        end
    endtask

    // What a reader of register a must see right now, before the edge.
    task automatic model_read(input logic [4:0] a, output logic [31:0] d,
                              output logic b);
        d = 32'h0;
        b = 1'b0;
        if (a != 0) begin
            d = mregs[a];
            b = mbusy[a];
`ifdef REGFILE_BYPASS_EN
            if (rf0.wa_en && rf0.wa_addr == a) begin
                d = rf0.wa_data;
                b = rf0.rsv_en && rf0.rsv_addr == a;
            end
            if (rf0.wb_en && rf0.wb_addr == a) begin
                d = rf0.wb_data;
                b = rf0.rsv_en && rf0.rsv_addr == a;
            end
`endif
        end
    endtask

    task automatic compare();
        logic [31:0] d;
        logic        b;
        logic [31:0] eb;
        for (int k = 0; k < 3; k++) begin
            model_read(rf0.rd_addr[k*5 +: 5], d, b);
            chk($sformatf("rd_data%0d", k), 64'(rf0.rd_data[k*32 +: 32]), 64'(d));
            chk($sformatf("rd_busy%0d", k), 64'(rf0.rd_busy[k]), 64'(b));
        end
        eb = '0;
        for (int i = 1; i < 32; i++) eb[i] = mbusy[i];
        chk("busy_vec", 64'(rf0.busy), 64'(eb));
    endtask

    task automatic model_update();
        if (rf0.wa_en && rf0.wa_addr != 0) begin
            mregs[rf0.wa_addr] = rf0.wa_data;
            mbusy[rf0.wa_addr] = 1'b0;
        end
        if (rf0.wb_en && rf0.wb_addr != 0) begin
            mregs[rf0.wb_addr] = rf0.wb_data;
            mbusy[rf0.wb_addr] = 1'b0;
        end
        if (rf0.rsv_en && rf0.rsv_addr != 0) mbusy[rf0.rsv_addr] = 1'b1;
    endtask

    task automatic settle();
        #2;
        compare();
    endtask

    task automatic tick();
        model_update();
        @(negedge clk);
    endtask

    task automatic idle0();
        rf0.wa_en = 0; rf0.wa_addr = 0; rf0.wa_data = 0;
        rf0.wb_en = 0; rf0.wb_addr = 0; rf0.wb_data = 0;
        rf0.rsv_en = 0; rf0.rsv_addr = 0;
    endtask

    task automatic rd0(input logic [4:0] a, input logic [4:0] b,
                       input logic [4:0] c);
        rf0.rd_addr = {c, b, a};
    endtask

    function automatic logic [4:0] raddr();
        if ($urandom_range(0, 3) != 0) return 5'($urandom_range(0, 7));
        return 5'($urandom_range(0, 31));
    endfunction

    initial begin
        reset = 1'b1;
        idle0();
        rd0(1, 2, 3);
        rf1.rd_addr = '0;
        rf1.wa_en = 0; rf1.wa_addr = 0; rf1.wa_data = 0;
        rf1.wb_en = 0; rf1.wb_addr = 0; rf1.wb_data = 0;
        rf1.rsv_en = 0; rf1.rsv_addr = 0;
        model_clear();
        repeat (2) @(negedge clk);
        #1;
        chk("reset_rd_data", 64'(rf0.rd_data), 64'h0);
        chk("reset_busy", 64'(rf0.busy), 64'h0);
        chk("reset_rd_busy", 64'(rf0.rd_busy), 64'h0);
        @(negedge clk);
        reset = 1'b0;

        // x0 ignores writes and reservations
        rd0(0, 0, 0);
        rf0.wa_en = 1; rf0.wa_addr = 0; rf0.wa_data = 32'h1234;
        rf0.rsv_en = 1; rf0.rsv_addr = 0;
        settle(); tick();
        idle0();
        settle();
        chk("x0_data", 64'(rf0.rd_data[31:0]), 64'h0);
        chk("x0_busy", 64'(rf0.busy), 64'h0);
        tick();

        // dual write, same and distinct addresses
        rf0.wa_en = 1; rf0.wa_addr = 7; rf0.wa_data = 32'h11111111;
        rf0.wb_en = 1; rf0.wb_addr = 7; rf0.wb_data = 32'h22222222;
        settle(); tick();
        rf0.wa_addr = 3; rf0.wa_data = 32'h33;
        rf0.wb_addr = 4; rf0.wb_data = 32'h44;
        settle(); tick();
        idle0();
        rd0(7, 3, 4);
        settle();
        chk("dual_same_b_wins", 64'(rf0.rd_data[31:0]), 64'h22222222);
        chk("dual_x3", 64'(rf0.rd_data[63:32]), 64'h33);
        chk("dual_x4", 64'(rf0.rd_data[95:64]), 64'h44);
        tick();

        // scoreboard
        rd0(9, 9, 9);
        rf0.rsv_en = 1; rf0.rsv_addr = 9;
        settle(); tick();
        idle0();
        settle();
        chk("rsv_busy9", 64'(rf0.busy[9]), 64'h1);
        chk("rsv_rd_busy", 64'(rf0.rd_busy), 64'h7);
        rf0.wb_en = 1; rf0.wb_addr = 9; rf0.wb_data = 32'hCAFE;
        settle(); tick();
        idle0();
        settle();
        chk("clr_busy9", 64'(rf0.busy[9]), 64'h0);
        chk("clr_data9", 64'(rf0.rd_data[31:0]), 64'hCAFE);
        rf0.rsv_en = 1; rf0.rsv_addr = 9;
        rf0.wa_en = 1; rf0.wa_addr = 9; rf0.wa_data = 32'hBEEF;
        settle(); tick();
        idle0();
        settle();
        chk("rsv_wins_busy9", 64'(rf0.busy[9]), 64'h1);
        chk("rsv_wins_data9", 64'(rf0.rd_data[31:0]), 64'hBEEF);
        tick();

        // bypass window on all three ports
        rd0(12, 12, 12);
        rf0.wa_en = 1; rf0.wa_addr = 12; rf0.wa_data = 32'hA5A5A5A5;
        settle();
`ifdef REGFILE_BYPASS_EN
        chk("byp_same_cycle", 64'(rf0.rd_data[95:0] == {3{32'hA5A5A5A5}}), 64'h1);
`else
        chk("byp_same_cycle", 64'(rf0.rd_data[95:0]), 64'h0);
`endif
        tick();
        idle0();
        settle();
        chk("byp_after_edge", 64'(rf0.rd_data[95:0] == {3{32'hA5A5A5A5}}), 64'h1);
        tick();

        // randomized traffic
        for (int n = 0; n < 400; n++) begin
            rd0(raddr(), raddr(), raddr());
            rf0.wa_en = 1'($urandom); rf0.wa_addr = raddr(); rf0.wa_data = $urandom;
            rf0.wb_en = 1'($urandom); rf0.wb_addr = raddr(); rf0.wb_data = $urandom;
            rf0.rsv_en = ($urandom_range(0, 2) == 0);
            rf0.rsv_addr = raddr();
            settle(); tick();
        end

        // asynchronous reset between edges
        idle0();
        rf0.wa_en = 1; rf0.wa_addr = 5; rf0.wa_data = 32'hDEADBEEF;
        rf0.rsv_en = 1; rf0.rsv_addr = 20;
        settle(); tick();
        idle0();
        rd0(5, 20, 0);
        settle();
        chk("pre_reset_x5", 64'(rf0.rd_data[31:0]), 64'hDEADBEEF);
        chk("pre_reset_busy20", 64'(rf0.busy[20]), 64'h1);
        reset = 1'b1;
        #1;
        chk("async_reset_x5", 64'(rf0.rd_data[31:0]), 64'h0);
        chk("async_reset_busy", 64'(rf0.busy), 64'h0);
        model_clear();
        @(negedge clk);
        reset = 1'b0;
        settle();
        chk("post_reset_busy", 64'(rf0.busy), 64'h0);
        tick();

        // 16-bit, 16-register, 4-port instance
        rf1.rd_addr = {4{4'd15}};
        rf1.wa_en = 1; rf1.wa_addr = 15; rf1.wa_data = 16'hFFFF;
        rf1.rsv_en = 1; rf1.rsv_addr = 15;
        @(negedge clk);
        rf1.wa_en = 0; rf1.rsv_en = 0;
        #2;
        chk("p16_rd_data", 64'(rf1.rd_data), 64'hFFFF_FFFF_FFFF_FFFF);
        chk("p16_rd_busy", 64'(rf1.rd_busy), 64'hF);
        chk("p16_busy_vec", 64'(rf1.busy), 64'h8000);
        rf1.rd_addr = {4'd0, 4'd15, 4'd0, 4'd15};
        #1;
        chk("p16_mixed", 64'(rf1.rd_data), 64'h0000_FFFF_0000_FFFF);
        @(negedge clk);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
